// File: rtl/bus_decoder.sv
// Single-master, N-slave address decoder and response router with a
// parametrised region table, lowest-index overlap priority, unmapped-address errors and timeout.
module bus_decoder #(
    parameter int unsigned                 NUM_REGIONS = 4,
    parameter logic [NUM_REGIONS*32-1:0]   BASE_ADDR   = {32'h80000000, 32'h02000000, 32'h01000000, 32'h00000000},
    parameter logic [NUM_REGIONS*32-1:0]   TOP_ADDR    = {32'h90000000, 32'h0200C000, 32'h01000004, 32'h00000080},
    parameter int unsigned                 TIMEOUT     = 1023
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        m_valid,
    input  logic                        m_instr,
    input  logic [31:0]                 m_addr,
    input  logic [31:0]                 m_wdata,
    input  logic [3:0]                  m_wstrb,
    output logic                        m_ready,
    output logic [31:0]                 m_rdata,
    output logic                        m_error,
    output logic [NUM_REGIONS-1:0]      s_valid,
    output logic                        s_instr,
    output logic [31:0]                 s_addr,
    output logic [31:0]                 s_wdata,
    output logic [3:0]                  s_wstrb,
    input  logic [NUM_REGIONS-1:0]      s_ready,
    input  logic [NUM_REGIONS*32-1:0]   s_rdata
);

    localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned SW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ERROR
    } state_t;

    state_t                 state, state_nx;
    logic [SW-1:0]          sel;
    logic [CW-1:0]          cnt;
    logic                   hit_found;
    logic [SW-1:0]          hit_idx;
    logic [NUM_REGIONS-1:0] hit_vec;
    logic                   accept;
    logic                   sel_ready;
    logic [31:0]            sel_rdata;
    logic                   timed_out;

    // First matching region in ascending index order wins on overlap.
    always_comb begin
        hit_found = 1'b0;
        hit_idx   = '0;
        hit_vec   = '0;
        for (int unsigned k = 0; k < NUM_REGIONS; k++) begin
            if (!hit_found && (m_addr >= BASE_ADDR[32*k +: 32]) && (m_addr < TOP_ADDR[32*k +: 32])) begin
                hit_found  = 1'b1;
                hit_idx    = SW'(k);
                hit_vec[k] = 1'b1;
            end
        end
    end

    assign sel_ready = s_ready[sel];
    assign sel_rdata = s_rdata[32*sel +: 32];
    assign timed_out = (TIMEOUT != 0) && (cnt == TO_VAL) && !sel_ready;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        m_ready  = 1'b0;
        m_error  = 1'b0;
        m_rdata  = '0;
        case (state)
            IDLE: begin
                if (m_valid) begin
                    if (hit_found) begin
                        accept   = 1'b1;
                        state_nx = BUSY;
                    end else begin
                        state_nx = ERROR;
                    end
                end
            end
            BUSY: begin
                m_rdata = sel_rdata;
                if (sel_ready) begin
                    m_ready  = 1'b1;
                    state_nx = IDLE;
                end else if (timed_out) begin
                    m_ready  = 1'b1;
                    m_error  = 1'b1;
                    m_rdata  = '0;
                    state_nx = IDLE;
                end
            end
            ERROR: begin
                m_ready  = 1'b1;
                m_error  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            s_valid <= '0;
            s_instr <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_wstrb <= '0;
            sel     <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nx;
            s_valid <= '0;
            if (accept) begin
                s_valid <= hit_vec;
                s_instr <= m_instr;
                s_addr  <= m_addr;
                s_wdata <= m_wdata;
                s_wstrb <= m_wstrb;
                sel     <= hit_idx;
                cnt     <= '0;
            end else if ((state == BUSY) && (cnt != CNT_MAX)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_decoder.sv
// Directed bench for bus_decoder: default map instance plus a two-region
// overlapping map with an 8-cycle timeout.
module tb_bus_decoder;

    logic        clock = 1'b0;
    logic        reset;
    int unsigned checks = 0;
    int unsigned errors = 0;

    // Default-map instance
    logic         a_m_valid, a_m_instr, a_m_ready, a_m_error, a_s_instr;
    logic [31:0]  a_m_addr, a_m_wdata, a_m_rdata, a_s_addr, a_s_wdata;
    logic [3:0]   a_m_wstrb, a_s_wstrb, a_s_valid, a_s_ready;
    logic [127:0] a_s_rdata;

    // Overlapping-map instance with short timeout
    logic         b_m_valid, b_m_instr, b_m_ready, b_m_error, b_s_instr;
    logic [31:0]  b_m_addr, b_m_wdata, b_m_rdata, b_s_addr, b_s_wdata;
    logic [3:0]   b_m_wstrb, b_s_wstrb;
    logic [1:0]   b_s_valid, b_s_ready;
    logic [63:0]  b_s_rdata;

    always #5 clock = ~clock;

    bus_decoder dut_a (
        .clock(clock), .reset(reset),
        .m_valid(a_m_valid), .m_instr(a_m_instr), .m_addr(a_m_addr), .m_wdata(a_m_wdata),
        .m_wstrb(a_m_wstrb), .m_ready(a_m_ready), .m_rdata(a_m_rdata), .m_error(a_m_error),
        .s_valid(a_s_valid), .s_instr(a_s_instr), .s_addr(a_s_addr), .s_wdata(a_s_wdata),
        .s_wstrb(a_s_wstrb), .s_ready(a_s_ready), .s_rdata(a_s_rdata)
    );

    bus_decoder #(
        .NUM_REGIONS(2),
        .BASE_ADDR  ({32'h80000000, 32'h80000000}),
        .TOP_ADDR   ({32'h90000000, 32'h80008000}),
        .TIMEOUT    (8)
    ) dut_b (
        .clock(clock), .reset(reset),
        .m_valid(b_m_valid), .m_instr(b_m_instr), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
        .m_wstrb(b_m_wstrb), .m_ready(b_m_ready), .m_rdata(b_m_rdata), .m_error(b_m_error),
        .s_valid(b_s_valid), .s_instr(b_s_instr), .s_addr(b_s_addr), .s_wdata(b_s_wdata),
        .s_wstrb(b_s_wstrb), .s_ready(b_s_ready), .s_rdata(b_s_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        a_m_valid = 1'b0; a_m_instr = 1'b0; a_m_addr = '0; a_m_wdata = '0; a_m_wstrb = '0;
        a_s_ready = '0;
        a_s_rdata = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
        b_m_valid = 1'b0; b_m_instr = 1'b0; b_m_addr = '0; b_m_wdata = '0; b_m_wstrb = '0;
        b_s_ready = '0;
        b_s_rdata = {32'hBBBB0001, 32'hAAAA0000};

        @(negedge clock);
        chk("rst_m_ready", a_m_ready, 0);
        chk("rst_m_error", a_m_error, 0);
        chk("rst_m_rdata", a_m_rdata, 0);
        chk("rst_s_valid", a_s_valid, 0);
        chk("rst_s_addr",  a_s_addr,  0);
        chk("rst_s_wdata", a_s_wdata, 0);
        chk("rst_s_wstrb", a_s_wstrb, 0);
        chk("rst_s_instr", a_s_instr, 0);
        cyc();
        reset = 1'b0;

        // Read 0x40, slave 0 answers in its s_valid cycle
        a_m_valid = 1'b1; a_m_addr = 32'h40; a_m_wstrb = 4'h0; a_m_instr = 1'b1;
        @(negedge clock);
        chk("rd0_req_ready", a_m_ready, 0);
        cyc();
        a_m_valid = 1'b0; a_s_ready = 4'b0001;
        @(negedge clock);
        chk("rd0_s_valid", a_s_valid, 4'b0001);
        chk("rd0_m_ready", a_m_ready, 1);
        chk("rd0_m_rdata", a_m_rdata, 32'hDEADBEEF);
        chk("rd0_m_error", a_m_error, 0);
        chk("rd0_s_instr", a_s_instr, 1);
        cyc();
        a_s_ready = '0;
        @(negedge clock);
        chk("rd0_after_valid", a_s_valid, 0);
        chk("rd0_after_ready", a_m_ready, 0);

        // Write to slave 2, response 3 cycles after s_valid; a stray request mid-flight is dropped
        cyc();
        a_m_valid = 1'b1; a_m_instr = 1'b0; a_m_addr = 32'h02004000; a_m_wdata = 32'h12345678; a_m_wstrb = 4'hF;
        cyc();
        a_m_valid = 1'b0; a_s_ready = 4'b1011;
        @(negedge clock);
        chk("wr_s_valid",  a_s_valid, 4'b0100);
        chk("wr_s_addr",   a_s_addr,  32'h02004000);
        chk("wr_s_wdata",  a_s_wdata, 32'h12345678);
        chk("wr_s_wstrb",  a_s_wstrb, 4'hF);
        chk("wr_t1_ready", a_m_ready, 0);
        cyc();
        a_m_valid = 1'b1; a_m_addr = 32'h80;
        @(negedge clock);
        chk("wr_t2_valid", a_s_valid, 0);
        chk("wr_t2_addr",  a_s_addr,  32'h02004000);
        chk("wr_t2_ready", a_m_ready, 0);
        cyc();
        a_m_valid = 1'b0; a_m_addr = '0;
        @(negedge clock);
        chk("wr_t3_ready", a_m_ready, 0);
        chk("wr_t3_error", a_m_error, 0);
        chk("wr_t3_wdata", a_s_wdata, 32'h12345678);
        cyc();
        a_s_ready = 4'b0100;
        @(negedge clock);
        chk("wr_t4_ready", a_m_ready, 1);
        chk("wr_t4_error", a_m_error, 0);
        chk("wr_t4_rdata", a_m_rdata, 32'h22222222);
        cyc();
        a_s_ready = '0;

        // Exclusive top of region 0 is unmapped; s_ready outside BUSY is ignored
        a_m_valid = 1'b1; a_m_addr = 32'h00000080; a_m_wstrb = 4'h0;
        @(negedge clock);
        chk("top0_req_ready", a_m_ready, 0);
        cyc();
        a_m_valid = 1'b0; a_s_ready = 4'hF;
        @(negedge clock);
        chk("top0_m_ready", a_m_ready, 1);
        chk("top0_m_error", a_m_error, 1);
        chk("top0_m_rdata", a_m_rdata, 0);
        chk("top0_s_valid", a_s_valid, 0);
        cyc();
        a_s_ready = '0;
        @(negedge clock);
        chk("top0_after_ready", a_m_ready, 0);
        chk("top0_after_error", a_m_error, 0);

        // Last word of region 3
        a_m_valid = 1'b1; a_m_addr = 32'h8FFFFFFC;
        cyc();
        a_m_valid = 1'b0; a_s_ready = 4'b1000;
        @(negedge clock);
        chk("r3_s_valid", a_s_valid, 4'b1000);
        chk("r3_m_ready", a_m_ready, 1);
        chk("r3_m_rdata", a_m_rdata, 32'h33333333);
        chk("r3_m_error", a_m_error, 0);
        cyc();
        a_s_ready = '0;

        // Exclusive top of region 3
        a_m_valid = 1'b1; a_m_addr = 32'h90000000;
        cyc();
        a_m_valid = 1'b0;
        @(negedge clock);
        chk("top3_m_ready", a_m_ready, 1);
        chk("top3_m_error", a_m_error, 1);
        chk("top3_s_valid", a_s_valid, 0);
        cyc();

        // Asynchronous reset while BUSY
        a_m_valid = 1'b1; a_m_addr = 32'h40;
        cyc();
        a_m_valid = 1'b0;
        @(negedge clock);
        chk("abort_s_valid_pre", a_s_valid, 4'b0001);
        chk("abort_ready_pre",   a_m_ready, 0);
        #1;
        reset = 1'b1; a_s_ready = 4'b0001;
        #1;
        chk("abort_m_ready", a_m_ready, 0);
        chk("abort_m_rdata", a_m_rdata, 0);
        chk("abort_s_valid", a_s_valid, 0);
        chk("abort_s_addr",  a_s_addr,  0);
        cyc();
        reset = 1'b0;
        @(negedge clock);
        chk("abort_post_ready", a_m_ready, 0);
        a_s_ready = '0;
        cyc();
        a_m_valid = 1'b1; a_m_addr = 32'h01000000;
        cyc();
        a_m_valid = 1'b0; a_s_ready = 4'b0010;
        @(negedge clock);
        chk("r1_s_valid", a_s_valid, 4'b0010);
        chk("r1_s_addr",  a_s_addr,  32'h01000000);
        chk("r1_m_ready", a_m_ready, 1);
        chk("r1_m_rdata", a_m_rdata, 32'h11111111);
        chk("r1_m_error", a_m_error, 0);
        cyc();
        a_s_ready = '0;

        // Overlap: lowest index wins where both regions match
        b_m_valid = 1'b1; b_m_addr = 32'h80000010;
        cyc();
        b_m_valid = 1'b0; b_s_ready = 2'b01;
        @(negedge clock);
        chk("ovl_lo_s_valid", b_s_valid, 2'b01);
        chk("ovl_lo_rdata",   b_m_rdata, 32'hAAAA0000);
        chk("ovl_lo_ready",   b_m_ready, 1);
        cyc();
        b_s_ready = '0;
        b_m_valid = 1'b1; b_m_addr = 32'h80010000;
        cyc();
        b_m_valid = 1'b0; b_s_ready = 2'b10;
        @(negedge clock);
        chk("ovl_hi_s_valid", b_s_valid, 2'b10);
        chk("ovl_hi_rdata",   b_m_rdata, 32'hBBBB0001);
        chk("ovl_hi_ready",   b_m_ready, 1);
        cyc();
        b_s_ready = '0;

        // Timeout: silent slave, error exactly 8 cycles after s_valid
        b_m_valid = 1'b1; b_m_addr = 32'h80000010;
        cyc();
        b_m_valid = 1'b0;
        @(negedge clock);
        chk("to_s_valid", b_s_valid, 2'b01);
        chk("to_wait1",   b_m_ready, 0);
        for (int i = 2; i <= 8; i++) begin
            cyc();
            @(negedge clock);
            chk($sformatf("to_wait%0d", i), b_m_ready, 0);
        end
        cyc();
        @(negedge clock);
        chk("to_m_ready", b_m_ready, 1);
        chk("to_m_error", b_m_error, 1);
        chk("to_m_rdata", b_m_rdata, 0);
        cyc();
        @(negedge clock);
        chk("to_after_ready", b_m_ready, 0);
        cyc();
        b_s_ready = 2'b01;
        @(negedge clock);
        chk("to_late_ready", b_m_ready, 0);
        chk("to_late_error", b_m_error, 0);
        cyc();
        b_s_ready = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
